// File: rtl/apb_gpio_gen2.sv
// apb_gpio_gen2: APB GPIO controller with NUM_GPIO pins, 2-flop input sync,
// sticky W1C interrupt status and atomic set/clear/toggle on the output register.
// Optional per-pin debounce filter: define GPIO_DEBOUNCE_EN.
module apb_gpio_gen2 #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_GPIO       = 32,
    parameter int DB_CNT_W       = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_GPIO-1:0]       gpio_in,
    output logic [NUM_GPIO-1:0]       gpio_in_sync,
    output logic [NUM_GPIO-1:0]       gpio_out,
    output logic [NUM_GPIO-1:0]       gpio_dir,
    output logic                      interrupt
);
    localparam logic [3:0] A_DIR      = 4'h0;
    localparam logic [3:0] A_IN       = 4'h1;
    localparam logic [3:0] A_OUT      = 4'h2;
    localparam logic [3:0] A_OUTSET   = 4'h3;
    localparam logic [3:0] A_OUTCLR   = 4'h4;
    localparam logic [3:0] A_OUTTGL   = 4'h5;
    localparam logic [3:0] A_INTEN    = 4'h6;
    localparam logic [3:0] A_INTTYPE0 = 4'h7;
    localparam logic [3:0] A_INTTYPE1 = 4'h8;
    localparam logic [3:0] A_INTSTAT  = 4'h9;
    localparam logic [3:0] A_DBTHRESH = 4'hA;
    localparam logic [3:0] A_DBEN     = 4'hB;

    typedef logic [NUM_GPIO-1:0] pins_t;

    pins_t       r_dir, r_out, r_inten, r_type0, r_type1, r_status;
    pins_t       r_sync0, r_sync1, r_stable, r_stable_d;
    logic [3:0]  w_word;
    logic        w_mapped, w_access, w_wr;
    pins_t       w_wd, w_w1c, w_event, w_rd_pins, w_rd_dben;
    logic [31:0] w_rd_word, w_rd_dbthresh;
    logic        w_unused_bus;

    // Only PADDR[5:2] selects a word; the rest of the window aliases
    assign w_word       = PADDR[5:2];
    assign w_mapped     = (w_word <= A_DBEN);
    assign w_access     = PSEL & PENABLE;
    assign w_wr         = w_access & PWRITE & w_mapped;
    assign w_wd         = PWDATA[NUM_GPIO-1:0];
    assign w_unused_bus = ^{PADDR, PWDATA};

    // Control register writes, including atomic set/clear/toggle on OUT
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_dir   <= '0;
            r_out   <= '0;
            r_inten <= '0;
            r_type0 <= '0;
            r_type1 <= '0;
        end else if (w_wr) begin
            case (w_word)
                A_DIR:      r_dir   <= w_wd;
                A_OUT:      r_out   <= w_wd;
                A_OUTSET:   r_out   <= r_out | w_wd;
                A_OUTCLR:   r_out   <= r_out & ~w_wd;
                A_OUTTGL:   r_out   <= r_out ^ w_wd;
                A_INTEN:    r_inten <= w_wd;
                A_INTTYPE0: r_type0 <= w_wd;
                A_INTTYPE1: r_type1 <= w_wd;
                default:    ;
            endcase
        end
    end

    // Two-flop synchroniser on the raw pads, plus delayed filter output for edges
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_sync0    <= '0;
            r_sync1    <= '0;
            r_stable_d <= '0;
        end else begin
            r_sync0    <= gpio_in;
            r_sync1    <= r_sync0;
            r_stable_d <= r_stable;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [DB_CNT_W-1:0] r_dbthresh;
    pins_t               r_dben;
    logic [DB_CNT_W-1:0] r_cnt [NUM_GPIO];
    logic [DB_CNT_W-1:0] w_thm1;
    logic                w_db_on;

    assign w_thm1  = r_dbthresh - DB_CNT_W'(1);
    assign w_db_on = (r_dbthresh != '0);

    // Debounce configuration registers
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_dbthresh <= '0;
            r_dben     <= '0;
        end else if (w_wr) begin
            if (w_word == A_DBTHRESH) r_dbthresh <= PWDATA[DB_CNT_W-1:0];
            if (w_word == A_DBEN)     r_dben     <= w_wd;
        end
    end

    // Per-pin filter: a change must persist DBTHRESH samples to reach stable;
    // the compare happens before the increment so the counter never wraps
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_stable <= '0;
            for (int i = 0; i < NUM_GPIO; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_GPIO; i++) begin
                if (!r_dben[i] || !w_db_on) begin
                    r_stable[i] <= r_sync1[i];
                    r_cnt[i]    <= '0;
                end else if (r_sync1[i] == r_stable[i]) begin
                    r_cnt[i]    <= '0;
                end else if (r_cnt[i] == w_thm1) begin
                    r_stable[i] <= r_sync1[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i]    <= r_cnt[i] + DB_CNT_W'(1);
                end
            end
        end
    end

    assign w_rd_dbthresh = 32'(r_dbthresh);
    assign w_rd_dben     = r_dben;
`else
    logic [DB_CNT_W-1:0] w_unused_db;
    assign w_unused_db = '0;

    // Filter permanently bypassed: stable follows the synchroniser
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) r_stable <= '0;
        else         r_stable <= r_sync1;
    end

    assign w_rd_dbthresh = '0;
    assign w_rd_dben     = '0;
`endif

    // Per-pin event select by {INTTYPE1,INTTYPE0}: level high/low, rise, fall
    assign w_event = (~r_type1 & ~r_type0 &  r_stable)
                   | (~r_type1 &  r_type0 & ~r_stable)
                   | ( r_type1 & ~r_type0 &  r_stable & ~r_stable_d)
                   | ( r_type1 &  r_type0 & ~r_stable &  r_stable_d);
    assign w_w1c   = (w_wr && (w_word == A_INTSTAT)) ? w_wd : '0;

    // Sticky status: a same-cycle event overrides the W1C clear
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) r_status <= '0;
        else         r_status <= (r_status & ~w_w1c) | (w_event & r_inten);
    end

    // Combinational read mux; write-only and unmapped words read 0
    always_comb begin
        w_rd_pins = '0;
        w_rd_word = '0;
        case (w_word)
            A_DIR:      w_rd_pins = r_dir;
            A_IN:       w_rd_pins = r_stable;
            A_OUT:      w_rd_pins = r_out;
            A_INTEN:    w_rd_pins = r_inten;
            A_INTTYPE0: w_rd_pins = r_type0;
            A_INTTYPE1: w_rd_pins = r_type1;
            A_INTSTAT:  w_rd_pins = r_status;
            A_DBTHRESH: w_rd_word = w_rd_dbthresh;
            A_DBEN:     w_rd_pins = w_rd_dben;
            default:    ;
        endcase
    end

    assign PRDATA       = PSEL ? (32'(w_rd_pins) | w_rd_word) : '0;
    assign PREADY       = 1'b1;
    assign PSLVERR      = w_access & ~w_mapped;
    assign gpio_in_sync = r_sync1;
    assign gpio_out     = r_out;
    assign gpio_dir     = r_dir;
    assign interrupt    = |r_status;
endmodule
